lii_out_arbiter: RTL and testbench

- Round-robin, packet-locked scheduler that shares one LII physical output channel among N HLS kernel output streams.
- Sits between the kernel output AXI-Stream ports and the phy-out channel of a stream wrapper.
- Tags each beat with a per-stream src id and a runtime dst id.
- Drives the kernel clock-enable so the kernels stall cleanly under phy backpressure.

---
 rtl/lii_out_arbiter.sv | 161 ++++++++++++++++
 tb/tb_lii_out_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_out_arbiter.sv
// lii_out_arbiter
//
// Shares one LII physical output channel among N kernel output streams.
// Streams are picked round-robin. Once a stream starts a packet, the grant
// stays on that stream until its tlast beat, so packets never interleave on
// the output. Every beat is tagged with a per-stream source id
// (SRC_BASE + index) and with the destination id the kernel presents with
// that beat. The output is a single registered stage (obuf). The kernel
// clock enable follows the obuf's ability to take a beat, so the kernels
// stall cleanly under phy backpressure.
//
// Ports:
//   aclk, arst      clock, asynchronous active-high reset
//   s_tdata         N x DW kernel data, stream i at [i*DW +: DW]
//   s_tvalid        per-stream valid
//   s_tready        per-stream ready (only the granted stream can be ready)
//   s_tlast         per-stream end of packet
//   s_dst           N x 8 destination ids, stream i at [i*8 +: 8]
//   lii_out_tdata   granted data, zero-extended to PW
//   lii_out_tvalid  output valid (registered)
//   lii_out_tready  phy ready
//   lii_out_tlast   last beat of the packet
//   lii_out_src     SRC_BASE + granted index (mod 256)
//   lii_out_dst     destination id captured with the beat
//   ce              kernel clock enable
//   pkt_count       packets fully accepted into the output register (wraps)
module lii_out_arbiter #(
    parameter int N        = 4,
    parameter int DW       = 64,
    parameter int PW       = 256,
    parameter int SRC_BASE = 0
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N-1:0]    s_tlast,
    input  logic [N*8-1:0]  s_dst,
    output logic [PW-1:0]   lii_out_tdata,
    output logic            lii_out_tvalid,
    input  logic            lii_out_tready,
    output logic            lii_out_tlast,
    output logic [7:0]      lii_out_src,
    output logic [7:0]      lii_out_dst,
    output logic            ce,
    output logic [15:0]     pkt_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] lock_idx;

    logic [IW-1:0] grant;
    logic [IW-1:0] cand;
    logic          grant_valid;
    logic          can_load;
    logic          xfer;

    logic [DW-1:0] sel_data;
    logic [PW-1:0] sel_data_ext;
    logic          sel_last;
    logic [7:0]    sel_dst;
    logic [7:0]    sel_src;

    // The obuf can take a new beat when it is empty or being drained this
    // cycle; the kernels run exactly when that holds.
    assign can_load = !lii_out_tvalid || lii_out_tready;
    assign ce       = can_load;

    // Grant selection. While locked the owner keeps the grant even through
    // valid gaps, which is what keeps packets from interleaving. In IDLE the
    // search starts just after the last stream that finished a packet.
    always_comb begin
        grant       = '0;
        cand        = '0;
        grant_valid = 1'b0;
        if (state == ST_LOCKED) begin
            grant       = lock_idx;
            grant_valid = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = IW'((int'(last_grant) + k) % N);
                if (!grant_valid && s_tvalid[cand]) begin
                    grant       = cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Ready goes only to the granted stream and never depends on that
    // stream's own valid once locked. It is forced low during reset so a
    // kernel cannot believe a beat was taken while the arbiter is held.
    always_comb begin
        s_tready = '0;
        if (grant_valid && !arst) begin
            s_tready[grant] = can_load;
        end
    end

    // Mux out the granted stream's beat and its tags.
    always_comb begin
        sel_data               = s_tdata[int'(grant)*DW +: DW];
        sel_last               = s_tlast[grant];
        sel_dst                = s_dst[int'(grant)*8 +: 8];
        sel_src                = 8'(SRC_BASE + int'(grant));
        sel_data_ext           = '0;
        sel_data_ext[DW-1:0]   = sel_data;
    end

    assign xfer = grant_valid && s_tvalid[grant] && can_load;

    // Output register and packet-lock FSM. Both only move on a transfer,
    // except that an idle drain clears tvalid while leaving the last beat's
    // contents in place.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            lii_out_tvalid <= 1'b0;
            lii_out_tdata  <= '0;
            lii_out_tlast  <= 1'b0;
            lii_out_src    <= '0;
            lii_out_dst    <= '0;
            state          <= ST_IDLE;
            last_grant     <= IW'(N - 1);
            lock_idx       <= '0;
            pkt_count      <= '0;
        end else begin
            if (can_load) begin
                if (xfer) begin
                    lii_out_tvalid <= 1'b1;
                    lii_out_tdata  <= sel_data_ext;
                    lii_out_tlast  <= sel_last;
                    lii_out_src    <= sel_src;
                    lii_out_dst    <= sel_dst;
                end else begin
                    lii_out_tvalid <= 1'b0;
                end
            end

            if (xfer) begin
                if (sel_last) begin
                    state      <= ST_IDLE;
                    last_grant <= grant;
                    pkt_count  <= pkt_count + 16'd1;
                end else begin
                    state    <= ST_LOCKED;
                    lock_idx <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_lii_out_arbiter.sv
// tb_lii_out_arbiter
//
// Directed scenarios plus a randomized phase. Each stream has a queue of
// beats it wants to send; a behavioural model tracks round-robin ownership,
// packet locking and the single output register, and every cycle the DUT's
// ready/ce and output register are compared against it.
module tb_lii_out_arbiter;

    localparam int N        = 4;
    localparam int DW       = 64;
    localparam int PW       = 256;
    localparam int SRC_BASE = 0;

    logic            aclk = 1'b0;
    logic            arst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast;
    logic [N*8-1:0]  s_dst;
    logic [PW-1:0]   lii_out_tdata;
    logic            lii_out_tvalid;
    logic            lii_out_tready;
    logic            lii_out_tlast;
    logic [7:0]      lii_out_src;
    logic [7:0]      lii_out_dst;
    logic            ce;
    logic [15:0]     pkt_count;

    lii_out_arbiter #(
        .N        (N),
        .DW       (DW),
        .PW       (PW),
        .SRC_BASE (SRC_BASE)
    ) dut (
        .aclk           (aclk),
        .arst           (arst),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .s_dst          (s_dst),
        .lii_out_tdata  (lii_out_tdata),
        .lii_out_tvalid (lii_out_tvalid),
        .lii_out_tready (lii_out_tready),
        .lii_out_tlast  (lii_out_tlast),
        .lii_out_src    (lii_out_src),
        .lii_out_dst    (lii_out_dst),
        .ce             (ce),
        .pkt_count      (pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [7:0]  dst;
    } beat_t;

    // Pending beats per stream, per-stream valid gap, phy ready
    beat_t sq[N][$];
    bit    gap[N];
    bit    rdy;

    // Behavioural model state
    bit          m_locked;
    int          m_owner;
    int          m_last;
    logic [15:0] m_pkt;
    logic        m_ovalid;
    logic [255:0] m_odata;
    logic        m_olast;
    logic [7:0]  m_osrc;
    logic [7:0]  m_odst;

    // Beats seen leaving on the phy side (valid & ready)
    int          obs_src[$];
    logic [63:0] obs_data[$];
    logic        obs_last[$];
    logic [7:0]  obs_dst[$];

    int n_assert;
    int n_fail;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_pkt    = '0;
        m_ovalid = 1'b0;
        m_odata  = '0;
        m_olast  = 1'b0;
        m_osrc   = '0;
        m_odst   = '0;
    endtask

    task automatic clearQueues();
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            gap[i] = 1'b0;
        end
    endtask

    task automatic clearObs();
        obs_src.delete();
        obs_data.delete();
        obs_last.delete();
        obs_dst.delete();
    endtask

    task automatic pushBeat(input int s, input logic [63:0] d, input logic l, input logic [7:0] dst);
        beat_t b;
        b.data = d;
        b.last = l;
        b.dst  = dst;
        sq[s].push_back(b);
    endtask

    // Present each stream's head beat unless it is gapped; idle streams get
    // junk data so any leak from an ungranted stream shows up.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0 && !gap[i]) begin
                s_tvalid[i]           = 1'b1;
                s_tdata[i*DW +: DW]   = sq[i][0].data;
                s_tlast[i]            = sq[i][0].last;
                s_dst[i*8 +: 8]       = sq[i][0].dst;
            end else begin
                s_tvalid[i]           = 1'b0;
                s_tdata[i*DW +: DW]   = {$urandom, $urandom};
                s_tlast[i]            = 1'($urandom_range(0, 1));
                s_dst[i*8 +: 8]       = 8'($urandom);
            end
        end
        lii_out_tready = rdy;
    endtask

    // One clock cycle, starting and ending at a falling edge.
    task automatic tick();
        int          g;
        bit          gv;
        bit          cl;
        bit          xf;
        logic [N-1:0] exp_rdy;
        beat_t       b;
        applyStimulus();
        #1;
        if (lii_out_tvalid && lii_out_tready) begin
            obs_src.push_back(int'(lii_out_src));
            obs_data.push_back(lii_out_tdata[63:0]);
            obs_last.push_back(lii_out_tlast);
            obs_dst.push_back(lii_out_dst);
        end
        cl = !m_ovalid || rdy;
        gv = 1'b0;
        g  = 0;
        if (m_locked) begin
            g  = m_owner;
            gv = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!gv && s_tvalid[c]) begin
                    g  = c;
                    gv = 1'b1;
                end
            end
        end
        exp_rdy = '0;
        if (gv && cl) exp_rdy[g] = 1'b1;
        checkOutput("s_tready", 256'(s_tready), 256'(exp_rdy));
        checkOutput("ce", 256'(ce), 256'(cl));
        xf = gv && s_tvalid[g] && cl;
        if (xf) b = sq[g][0];

        @(posedge aclk);
        if (cl) begin
            if (xf) begin
                m_ovalid = 1'b1;
                m_odata  = 256'(b.data);
                m_olast  = b.last;
                m_osrc   = 8'(SRC_BASE + g);
                m_odst   = b.dst;
            end else begin
                m_ovalid = 1'b0;
            end
        end
        if (xf) begin
            if (b.last) begin
                m_locked = 1'b0;
                m_last   = g;
                m_pkt    = m_pkt + 16'd1;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
            void'(sq[g].pop_front());
        end
        #1;
        checkOutput("tvalid", 256'(lii_out_tvalid), 256'(m_ovalid));
        checkOutput("tdata", lii_out_tdata, m_odata);
        checkOutput("tlast", 256'(lii_out_tlast), 256'(m_olast));
        checkOutput("src", 256'(lii_out_src), 256'(m_osrc));
        checkOutput("dst", 256'(lii_out_dst), 256'(m_odst));
        checkOutput("pkt_count", 256'(pkt_count), 256'(m_pkt));
        @(negedge aclk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset (asynchronously, at whatever point we are in the cycle),
    // check the outputs clear at once, then release at the next falling edge.
    task automatic doReset();
        arst = 1'b1;
        #1;
        modelReset();
        clearQueues();
        checkOutput("rst_tvalid", 256'(lii_out_tvalid), 256'(0));
        checkOutput("rst_tdata", lii_out_tdata, 256'(0));
        checkOutput("rst_src", 256'(lii_out_src), 256'(0));
        checkOutput("rst_dst", 256'(lii_out_dst), 256'(0));
        checkOutput("rst_tlast", 256'(lii_out_tlast), 256'(0));
        checkOutput("rst_pkt", 256'(pkt_count), 256'(0));
        checkOutput("rst_tready", 256'(s_tready), 256'(0));
        checkOutput("rst_ce", 256'(ce), 256'(1));
        @(negedge aclk);
        arst = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_d[6];
        int          exp_s[6];
        logic        exp_l[6];

        n_assert       = 0;
        n_fail         = 0;
        arst           = 1'b1;
        s_tvalid       = '0;
        s_tdata        = '0;
        s_tlast        = '0;
        s_dst          = '0;
        lii_out_tready = 1'b0;
        rdy            = 1'b0;
        modelReset();
        clearQueues();
        @(negedge aclk);
        @(negedge aclk);
        $display("[TB] reset state");
        doReset();

        // Stream 2 alone sends a 3-beat packet
        $display("[TB] single stream 3-beat packet");
        rdy = 1'b1;
        pushBeat(2, 64'hA1, 1'b0, 8'h15);
        pushBeat(2, 64'hA2, 1'b0, 8'h15);
        pushBeat(2, 64'hA3, 1'b1, 8'h15);
        clearObs();
        ticks(5);
        exp_d[0] = 64'hA1; exp_d[1] = 64'hA2; exp_d[2] = 64'hA3;
        exp_l[0] = 1'b0;   exp_l[1] = 1'b0;   exp_l[2] = 1'b1;
        checkOutput("s2_count", 256'(obs_data.size()), 256'(3));
        for (int i = 0; i < 3; i++) begin
            checkOutput("s2_data", 256'(obs_data[i]), 256'(exp_d[i]));
            checkOutput("s2_src", 256'(obs_src[i]), 256'(2));
            checkOutput("s2_dst", 256'(obs_dst[i]), 256'(8'h15));
            checkOutput("s2_last", 256'(obs_last[i]), 256'(exp_l[i]));
        end
        checkOutput("s2_pkt", 256'(pkt_count), 256'(1));

        // All four streams hold single-beat packets: strict rotation 0..3
        $display("[TB] round-robin single beats");
        doReset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                pushBeat(i, 64'h300 + 64'(r*16 + i), 1'b1, 8'(i));
        clearObs();
        ticks(9);
        checkOutput("rr_count", 256'(obs_src.size()), 256'(8));
        for (int i = 0; i < 8; i++)
            checkOutput("rr_src", 256'(obs_src[i]), 256'(i % N));
        ticks(1);

        // Stream 0 packet with a 2-cycle valid gap; stream 1 waits for tlast
        $display("[TB] packet lock across valid gap");
        pushBeat(0, 64'hB0, 1'b0, 8'h20);
        pushBeat(0, 64'hB1, 1'b0, 8'h20);
        pushBeat(0, 64'hB2, 1'b0, 8'h20);
        pushBeat(0, 64'hB3, 1'b1, 8'h20);
        pushBeat(1, 64'hC0, 1'b0, 8'h21);
        pushBeat(1, 64'hC1, 1'b1, 8'h21);
        clearObs();
        ticks(2);
        gap[0] = 1'b1;
        ticks(2);
        gap[0] = 1'b0;
        ticks(6);
        exp_d[0] = 64'hB0; exp_d[1] = 64'hB1; exp_d[2] = 64'hB2;
        exp_d[3] = 64'hB3; exp_d[4] = 64'hC0; exp_d[5] = 64'hC1;
        exp_s[0] = 0; exp_s[1] = 0; exp_s[2] = 0; exp_s[3] = 0; exp_s[4] = 1; exp_s[5] = 1;
        checkOutput("gap_count", 256'(obs_data.size()), 256'(6));
        for (int i = 0; i < 6; i++) begin
            checkOutput("gap_data", 256'(obs_data[i]), 256'(exp_d[i]));
            checkOutput("gap_src", 256'(obs_src[i]), 256'(exp_s[i]));
        end

        // Phy backpressure for 5 cycles with the obuf full
        $display("[TB] backpressure hold");
        pushBeat(1, 64'hD0, 1'b0, 8'h31);
        pushBeat(1, 64'hD1, 1'b0, 8'h31);
        pushBeat(1, 64'hD2, 1'b1, 8'h31);
        rdy = 1'b1;
        ticks(1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_tdata", lii_out_tdata, 256'(64'hD0));
            checkOutput("bp_tready", 256'(s_tready), 256'(0));
            checkOutput("bp_ce", 256'(ce), 256'(0));
        end
        rdy = 1'b1;
        clearObs();
        ticks(4);
        exp_d[0] = 64'hD0; exp_d[1] = 64'hD1; exp_d[2] = 64'hD2;
        checkOutput("bp_count", 256'(obs_data.size()), 256'(3));
        for (int i = 0; i < 3; i++)
            checkOutput("bp_data", 256'(obs_data[i]), 256'(exp_d[i]));

        // Reset in the middle of a stream-3 packet
        $display("[TB] reset mid-packet");
        pushBeat(3, 64'hE0, 1'b0, 8'h43);
        pushBeat(3, 64'hE1, 1'b0, 8'h43);
        pushBeat(3, 64'hE2, 1'b0, 8'h43);
        pushBeat(3, 64'hE3, 1'b1, 8'h43);
        ticks(2);
        #2;
        doReset();
        pushBeat(1, 64'hF0, 1'b1, 8'h51);
        pushBeat(3, 64'hF3, 1'b1, 8'h53);
        clearObs();
        ticks(3);
        checkOutput("mrst_count", 256'(obs_src.size()), 256'(2));
        checkOutput("mrst_first", 256'(obs_src[0]), 256'(1));
        checkOutput("mrst_second", 256'(obs_src[1]), 256'(3));
        checkOutput("mrst_data", 256'(obs_data[0]), 256'(64'hF0));

        // Randomized traffic, gaps and backpressure
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (sq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++)
                        pushBeat(i, {$urandom, $urandom}, (j == len - 1), 8'($urandom));
                end
                gap[i] = ($urandom_range(0, 4) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        for (int i = 0; i < N; i++) gap[i] = 1'b0;
        rdy = 1'b1;
        ticks(24);

        // Counter wrap: 65537 single-beat packets
        $display("[TB] packet counter wrap");
        doReset();
        for (int i = 0; i < 65537; i++)
            pushBeat(0, 64'(i), 1'b1, 8'h0F);
        clearObs();
        ticks(65539);
        checkOutput("wrap_pkt", 256'(pkt_count), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
